// File: rtl/data_memory_map.sv
// data_memory_map: data-side responder for the single-cycle core, decoding word RAM and an I/O
// window with GPIO and a compare timer; loads are combinational, all state updates on the clock edge.
module data_memory_map #(
    parameter int unsigned memory_depth = 64,
    parameter logic [31:0] ram_base     = 32'h1001_0000,
    parameter logic [31:0] mmio_base    = 32'h1002_0000,
    parameter int unsigned gpio_width   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memwrite,
    input  logic                  memread,
    input  logic [31:0]           data_address,
    input  logic [31:0]           writedata,
    output logic [31:0]           received_data,
    input  logic [gpio_width-1:0] gpio_in,
    output logic [gpio_width-1:0] gpio_out,
    output logic                  timer_irq
);
    localparam int unsigned AW        = $clog2(memory_depth);
    localparam logic [31:0] RAM_BYTES = 32'(4 * memory_depth);
    localparam logic [2:0]  R_GPIO_OUT = 3'd0;
    localparam logic [2:0]  R_GPIO_IN  = 3'd1;
    localparam logic [2:0]  R_COUNT    = 3'd2;
    localparam logic [2:0]  R_COMPARE  = 3'd3;
    localparam logic [2:0]  R_CTRL     = 3'd4;
    localparam logic [2:0]  R_STATUS   = 3'd5;

    logic [31:0]           mem [memory_depth];
    logic [31:0]           ram_off, io_off, io_rdata;
    logic [31:0]           count_q, count_d, compare_q, compare_d;
    logic [gpio_width-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
    logic                  ctrl_q, ctrl_d, status_q, status_d;
    logic                  ram_hit, io_hit, io_we, match;
    logic [2:0]            sel;

    // Offsets below the base wrap to huge values, so one unsigned compare covers both bounds.
    assign ram_off = data_address - ram_base;
    assign io_off  = data_address - mmio_base;
    assign ram_hit = ram_off < RAM_BYTES;
    assign io_hit  = io_off < 32'h20;
    assign sel     = io_off[4:2];
    assign io_we   = memwrite && io_hit;
    assign match   = ctrl_q && (count_q == compare_q);

    always_comb begin
        gpio_out_d = (io_we && sel == R_GPIO_OUT) ? writedata[gpio_width-1:0] : gpio_out_q;
        count_d    = (io_we && sel == R_COUNT) ? writedata : ctrl_q ? count_q + 32'd1 : count_q;
        compare_d  = (io_we && sel == R_COMPARE) ? writedata : compare_q;
        ctrl_d     = (io_we && sel == R_CTRL) ? writedata[0] : ctrl_q;
        status_d   = match || (status_q && !(io_we && sel == R_STATUS && writedata[0]));
        io_rdata   = sel == R_GPIO_OUT ? 32'(gpio_out_q) :
                     sel == R_GPIO_IN  ? 32'(sync2_q)    :
                     sel == R_COUNT    ? count_q         :
                     sel == R_COMPARE  ? compare_q       :
                     sel == R_CTRL     ? {31'd0, ctrl_q} :
                     sel == R_STATUS   ? {31'd0, status_q} : 32'h0;
        received_data = !memread ? 32'h0 :
                        ram_hit  ? mem[ram_off[AW+1:2]] :
                        io_hit   ? io_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            count_q    <= 32'h0;
            compare_q  <= 32'hFFFF_FFFF;
            ctrl_q     <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
        end
    end

    // RAM contents survive reset; stores presented while reset is high are dropped.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && ram_hit)
            mem[ram_off[AW+1:2]] <= writedata;
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = status_q;
endmodule
